// File: rtl/mem_pkg.sv
// Shared definitions for the memory request queue.
// State encoding, default tag width and request field widths.
package mem_pkg;

  localparam int TAG_W_DEF = 8;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int WRITE_W   = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Packed request record width for a given tag width.
  function automatic int req_w(input int tag_w);
    return ADDR_W + DATA_W + tag_w + WRITE_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, registered count.
// Push is refused when full; pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];

  // Pointers wrap naturally; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/mem_request_queue.sv
// Load/store front end: FIFO of requests, one in flight at the cache.
// Results return to the pipeline in order, tagged.
module mem_request_queue
  import mem_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic              IN_WRITE,
  input  logic [TAG_W-1:0]  IN_TAG,
  input  logic [31:0]       IN_ADDR,
  input  logic [31:0]       IN_DATA,
  output logic              IN_READY,
  output logic              RECEIVE_ADDR_VALID,
  output logic [31:0]       RECEIVE_ADDR,
  output logic              RECEIVE_DATA_VALID,
  output logic [31:0]       RECEIVE_DATA,
  input  logic              RECEIVE_READY,
  input  logic              SEND_VALID,
  input  logic [31:0]       SEND_DATA,
  output logic              SEND_READY,
  output logic              OUT_VALID,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic              OUT_WRITE,
  output logic [31:0]       OUT_DATA,
  input  logic              OUT_READY
);

  localparam int RW = req_w(TAG_W);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [TAG_W-1:0] r_tag;
  logic             r_write;
  logic [31:0]      r_out_data;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [RW-1:0]    w_din;
  logic [RW-1:0]    w_dout;

  assign IN_READY = !RST && (w_count < CW'(DEPTH));
  assign w_push   = IN_VALID && IN_READY && !w_full;
  assign w_din    = {IN_WRITE, IN_TAG, IN_ADDR, IN_DATA};

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, pop strobe and state-decoded handshakes.
  always_comb begin
    w_next             = r_state;
    w_pop              = 1'b0;
    RECEIVE_ADDR_VALID = 1'b0;
    RECEIVE_DATA_VALID = 1'b0;
    SEND_READY         = 1'b0;
    OUT_VALID          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        RECEIVE_ADDR_VALID = 1'b1;
        RECEIVE_DATA_VALID = r_write;
        if (RECEIVE_READY) w_next = S_WAIT;
      end
      S_WAIT: begin
        SEND_READY = 1'b1;
        if (SEND_VALID) w_next = S_RESP;
      end
      S_RESP: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Issue registers load on pop; result data loads on cache reply.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_tag      <= '0;
      r_write    <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_pop) begin
        r_write <= w_dout[RW-1];
        r_tag   <= w_dout[RW-2 -: TAG_W];
        r_addr  <= w_dout[63:32];
        r_data  <= w_dout[31:0];
      end
      if (r_state == S_WAIT && SEND_VALID)
        r_out_data <= SEND_DATA;
    end
  end

  assign RECEIVE_ADDR = r_addr;
  assign RECEIVE_DATA = r_data;
  assign OUT_TAG      = r_tag;
  assign OUT_WRITE    = r_write;
  assign OUT_DATA     = r_out_data;

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue.
// One task per scenario, inline checks, single summary line.
module tb_mem_request_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_WRITE = 1'b0;
  logic [7:0]  IN_TAG = '0;
  logic [31:0] IN_ADDR = '0;
  logic [31:0] IN_DATA = '0;
  logic        IN_READY;
  logic        RECEIVE_ADDR_VALID;
  logic [31:0] RECEIVE_ADDR;
  logic        RECEIVE_DATA_VALID;
  logic [31:0] RECEIVE_DATA;
  logic        RECEIVE_READY = 1'b0;
  logic        SEND_VALID = 1'b0;
  logic [31:0] SEND_DATA = '0;
  logic        SEND_READY;
  logic        OUT_VALID;
  logic [7:0]  OUT_TAG;
  logic        OUT_WRITE;
  logic [31:0] OUT_DATA;
  logic        OUT_READY = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_request_queue #(.TAG_W(8), .DEPTH(4)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .IN_VALID           (IN_VALID),
    .IN_WRITE           (IN_WRITE),
    .IN_TAG             (IN_TAG),
    .IN_ADDR            (IN_ADDR),
    .IN_DATA            (IN_DATA),
    .IN_READY           (IN_READY),
    .RECEIVE_ADDR_VALID (RECEIVE_ADDR_VALID),
    .RECEIVE_ADDR       (RECEIVE_ADDR),
    .RECEIVE_DATA_VALID (RECEIVE_DATA_VALID),
    .RECEIVE_DATA       (RECEIVE_DATA),
    .RECEIVE_READY      (RECEIVE_READY),
    .SEND_VALID         (SEND_VALID),
    .SEND_DATA          (SEND_DATA),
    .SEND_READY         (SEND_READY),
    .OUT_VALID          (OUT_VALID),
    .OUT_TAG            (OUT_TAG),
    .OUT_WRITE          (OUT_WRITE),
    .OUT_DATA           (OUT_DATA),
    .OUT_READY          (OUT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one request until accepted or the budget runs out.
  task automatic push_req(input logic w, input logic [7:0] t,
                          input logic [31:0] a, input logic [31:0] d,
                          output bit acc);
    acc      = 1'b0;
    IN_VALID = 1'b1;
    IN_WRITE = w;
    IN_TAG   = t;
    IN_ADDR  = a;
    IN_DATA  = d;
    for (int i = 0; i < 50; i++) begin
      if (IN_READY) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (OUT_VALID) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, SEND_READY,
         OUT_VALID, IN_READY} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_valids got %b exp 00000",
               {RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, SEND_READY,
                OUT_VALID, IN_READY});
    end
    n_tests++;
    if ({RECEIVE_ADDR, RECEIVE_DATA, OUT_DATA, OUT_TAG, OUT_WRITE}
        !== 105'b0) begin
      n_fail++;
      $display("FAIL reset_payload got %h %h %h %h %b exp zeros",
               RECEIVE_ADDR, RECEIVE_DATA, OUT_DATA, OUT_TAG, OUT_WRITE);
    end
    RST = 1'b0;
    #1;
    n_tests++;
    if (IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b exp 1", IN_READY);
    end
  endtask

  task automatic test_single_load();
    bit acc;
    RECEIVE_READY = 1'b1;
    SEND_VALID    = 1'b1;
    SEND_DATA     = 32'hDEADBEEF;
    OUT_READY     = 1'b0;
    push_req(1'b0, 8'h05, 32'h100, 32'h0, acc);
    n_tests++;
    if (RECEIVE_ADDR_VALID !== 1'b0 || acc !== 1'b1) begin
      n_fail++;
      $display("FAIL load_k got rav=%b acc=%b exp 0 1",
               RECEIVE_ADDR_VALID, acc);
    end
    tick();
    n_tests++;
    if (RECEIVE_ADDR_VALID !== 1'b1 || RECEIVE_DATA_VALID !== 1'b0 ||
        RECEIVE_ADDR !== 32'h100) begin
      n_fail++;
      $display("FAIL load_issue got %b %b %h exp 1 0 00000100",
               RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, RECEIVE_ADDR);
    end
    tick();
    n_tests++;
    if (SEND_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wait got sr=%b ov=%b exp 1 0",
               SEND_READY, OUT_VALID);
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || OUT_TAG !== 8'h05 ||
        OUT_DATA !== 32'hDEADBEEF || OUT_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL load_result got %b %h %h %b exp 1 05 deadbeef 0",
               OUT_VALID, OUT_TAG, OUT_DATA, OUT_WRITE);
    end
    OUT_READY = 1'b1;
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL load_consume got %b exp 0", OUT_VALID);
    end
  endtask

  task automatic test_single_store();
    bit acc;
    bit bad;
    RECEIVE_READY = 1'b0;
    SEND_VALID    = 1'b1;
    SEND_DATA     = 32'h12345678;
    OUT_READY     = 1'b0;
    push_req(1'b1, 8'h11, 32'h200, 32'h12345678, acc);
    tick();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (RECEIVE_ADDR_VALID !== 1'b1 || RECEIVE_DATA_VALID !== 1'b1 ||
          RECEIVE_DATA !== 32'h12345678 || RECEIVE_ADDR !== 32'h200)
        bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad !== 1'b0 || acc !== 1'b1) begin
      n_fail++;
      $display("FAIL store_hold got bad=%b acc=%b exp 0 1", bad, acc);
    end
    RECEIVE_READY = 1'b1;
    tick();
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || OUT_WRITE !== 1'b1 ||
        OUT_DATA !== 32'h12345678 || OUT_TAG !== 8'h11) begin
      n_fail++;
      $display("FAIL store_result got %b %b %h %h exp 1 1 12345678 11",
               OUT_VALID, OUT_WRITE, OUT_DATA, OUT_TAG);
    end
    OUT_READY = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    bit acc0, acc1, ok, bad;
    RECEIVE_READY = 1'b1;
    SEND_VALID    = 1'b1;
    SEND_DATA     = 32'hCAFEF00D;
    OUT_READY     = 1'b0;
    push_req(1'b0, 8'h22, 32'h300, 32'h0, acc0);
    push_req(1'b0, 8'h23, 32'h304, 32'h0, acc1);
    wait_out(ok);
    n_tests++;
    if (ok !== 1'b1 || acc0 !== 1'b1 || acc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first got ok=%b acc=%b%b exp 1 11",
               ok, acc0, acc1);
    end
    SEND_DATA = 32'h11111111;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (OUT_VALID !== 1'b1 || OUT_TAG !== 8'h22 ||
          OUT_DATA !== 32'hCAFEF00D || SEND_READY !== 1'b0 ||
          RECEIVE_ADDR_VALID !== 1'b0)
        bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stable got %b %h %h sr=%b rav=%b exp 1 22 cafef00d 0 0",
               OUT_VALID, OUT_TAG, OUT_DATA, SEND_READY,
               RECEIVE_ADDR_VALID);
    end
    OUT_READY = 1'b1;
    tick();
    wait_out(ok);
    n_tests++;
    if (ok !== 1'b1 || OUT_TAG !== 8'h23 || OUT_DATA !== 32'h11111111) begin
      n_fail++;
      $display("FAIL bp_second got ok=%b %h %h exp 1 23 11111111",
               ok, OUT_TAG, OUT_DATA);
    end
    tick();
  endtask

  task automatic test_stray_send();
    bit acc, ok;
    OUT_READY  = 1'b1;
    SEND_VALID = 1'b1;
    SEND_DATA  = 32'hBAD0BAD0;
    #1;
    n_tests++;
    if (SEND_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_sr got %b exp 0", SEND_READY);
    end
    tick();
    SEND_VALID = 1'b0;
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ov got %b exp 0", OUT_VALID);
    end
    RECEIVE_READY = 1'b1;
    push_req(1'b0, 8'h33, 32'h400, 32'h0, acc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (SEND_READY) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    n_tests++;
    if (ok !== 1'b1 || OUT_VALID !== 1'b0 || acc !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_wait got ok=%b ov=%b acc=%b exp 1 0 1",
               ok, OUT_VALID, acc);
    end
    SEND_VALID = 1'b1;
    SEND_DATA  = 32'h55AA55AA;
    tick();
    SEND_VALID = 1'b0;
    n_tests++;
    if (OUT_VALID !== 1'b1 || OUT_TAG !== 8'h33 ||
        OUT_DATA !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL stray_result got %b %h %h exp 1 33 55aa55aa",
               OUT_VALID, OUT_TAG, OUT_DATA);
    end
    tick();
  endtask

  task automatic test_fill();
    bit acc;
    bit pushed;
    int got;
    int iss;
    RECEIVE_READY = 1'b0;
    OUT_READY     = 1'b1;
    SEND_VALID    = 1'b1;
    SEND_DATA     = 32'h0F0F0F0F;
    for (int t = 0; t < 5; t++) begin
      push_req(1'b0, 8'(t), 32'h1000 + 32'(4 * t), 32'h0, acc);
      n_tests++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_push%0d got %b exp 1", t, acc);
      end
    end
    n_tests++;
    if (IN_READY !== 1'b0 || RECEIVE_ADDR_VALID !== 1'b1 ||
        RECEIVE_ADDR !== 32'h1000) begin
      n_fail++;
      $display("FAIL fill_full got ir=%b rav=%b %h exp 0 1 00001000",
               IN_READY, RECEIVE_ADDR_VALID, RECEIVE_ADDR);
    end
    IN_VALID = 1'b1;
    IN_WRITE = 1'b0;
    IN_TAG   = 8'd5;
    IN_ADDR  = 32'h1014;
    tick();
    tick();
    tick();
    n_tests++;
    if (IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_refuse got %b exp 0", IN_READY);
    end
    RECEIVE_READY = 1'b1;
    got    = 0;
    iss    = 0;
    pushed = 1'b0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (RECEIVE_ADDR_VALID) begin
        n_tests++;
        if (RECEIVE_ADDR !== 32'h1000 + 32'(4 * iss)) begin
          n_fail++;
          $display("FAIL fill_issue%0d got %h exp %h", iss,
                   RECEIVE_ADDR, 32'h1000 + 32'(4 * iss));
        end
        iss++;
      end
      if (OUT_VALID) begin
        n_tests++;
        if (OUT_TAG !== 8'(got)) begin
          n_fail++;
          $display("FAIL fill_order got %h exp %h", OUT_TAG, 8'(got));
        end
        got++;
      end
      if (IN_VALID && IN_READY) begin
        n_tests++;
        if (got < 1) begin
          n_fail++;
          $display("FAIL fill_late_push got results=%0d exp >=1", got);
        end
        pushed = 1'b1;
        tick();
        IN_VALID = 1'b0;
      end else begin
        tick();
      end
    end
    IN_VALID = 1'b0;
    n_tests++;
    if (got != 6 || pushed !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_drain got %0d pushed=%b exp 6 1", got, pushed);
    end
  endtask

  task automatic test_reset_mid();
    bit a0, a1, a2, seen;
    RECEIVE_READY = 1'b1;
    SEND_VALID    = 1'b0;
    OUT_READY     = 1'b1;
    push_req(1'b0, 8'h40, 32'h500, 32'h0, a0);
    push_req(1'b1, 8'h41, 32'h504, 32'hAA, a1);
    push_req(1'b0, 8'h42, 32'h508, 32'h0, a2);
    n_tests++;
    if (SEND_READY !== 1'b1 || {a0, a1, a2} !== 3'b111) begin
      n_fail++;
      $display("FAIL rmid_wait got sr=%b acc=%b%b%b exp 1 111",
               SEND_READY, a0, a1, a2);
    end
    RST = 1'b1;
    tick();
    n_tests++;
    if ({RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, SEND_READY,
         OUT_VALID, IN_READY} !== 5'b0) begin
      n_fail++;
      $display("FAIL rmid_valids got %b exp 00000",
               {RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, SEND_READY,
                OUT_VALID, IN_READY});
    end
    RST = 1'b0;
    #1;
    n_tests++;
    if (IN_READY !== 1'b1 || OUT_TAG !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_release got ir=%b tag=%h exp 1 00",
               IN_READY, OUT_TAG);
    end
    SEND_VALID = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (OUT_VALID || RECEIVE_ADDR_VALID) seen = 1'b1;
    end
    SEND_VALID = 1'b0;
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_stale got %b exp 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_backpressure();
    test_stray_send();
    test_fill();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
